control_store_seq: RTL

CONTROL_STORE_SEQ -- requirements
Module: control_store_seq

---
 rtl/control_store_seq_if.sv | 34 +++
 rtl/control_store_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/control_store_seq_if.sv
// Handshake, programming and status bundle for the micro-code control-store sequencer.
// The master side dispatches and programs; the slave side (the sequencer) emits control words.
interface control_store_seq_if #(
    parameter int ADDR_W = 12,
    parameter int CTRL_W = 19
) ();
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_last;
    logic              out_illegal;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [CTRL_W-1:0] prog_ctrl;
    logic [ADDR_W-1:0] prog_next;
    logic              prog_last;
    logic              flush;
    logic              busy;

    modport master (
        output in_valid, in_addr, out_ready, prog_we, prog_addr, prog_ctrl,
               prog_next, prog_last, flush,
        input  in_ready, out_valid, out_ctrl, out_last, out_illegal, busy
    );

    modport slave (
        input  in_valid, in_addr, out_ready, prog_we, prog_addr, prog_ctrl,
               prog_next, prog_last, flush,
        output in_ready, out_valid, out_ctrl, out_last, out_illegal, busy
    );
endinterface

// File: rtl/control_store_seq.sv
// Micro-coded control store: a dispatch key selects a table entry, then the sequencer
// walks the next-pointer chain emitting one registered control word per handshake.
module control_store_seq #(
    parameter int ADDR_W    = 12,
    parameter int CTRL_W    = 19,
    parameter int MAX_STEPS = 8
) (
    input logic                clk,
    input logic                rst_n,
    control_store_seq_if.slave bus
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int ENTRY_W = CTRL_W + ADDR_W + 1;
    localparam int STEP_W  = 9;
    localparam logic [STEP_W-1:0] MAX_STEPS_C = STEP_W'(MAX_STEPS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Entry layout is {last, next, ctrl}.
    function automatic logic [CTRL_W-1:0] entry_ctrl(input logic [ENTRY_W-1:0] e);
        return e[CTRL_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] entry_next(input logic [ENTRY_W-1:0] e);
        return e[CTRL_W +: ADDR_W];
    endfunction

    function automatic logic entry_last(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1];
    endfunction

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]   valid_r;

    logic [0:0]        state_r,       state_s;
    logic              out_valid_r,   out_valid_s;
    logic [CTRL_W-1:0] out_ctrl_r,    out_ctrl_s;
    logic              out_last_r,    out_last_s;
    logic              out_illegal_r, out_illegal_s;
    logic [ADDR_W-1:0] upc_r,         upc_s;
    logic [STEP_W-1:0] step_cnt_r,    step_cnt_s;

    logic [ENTRY_W-1:0] disp_entry_s;
    logic               disp_valid_s;
    logic [ENTRY_W-1:0] run_entry_s;
    logic               run_valid_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               hs_s;

    // Combinational table reads: they see pre-write contents on a same-cycle write.
    assign disp_entry_s = mem_r[bus.in_addr];
    assign disp_valid_s = valid_r[bus.in_addr];
    assign run_entry_s  = mem_r[upc_r];
    assign run_valid_s  = valid_r[upc_r];

    // Dispatch is only offered from IDLE when the output slot frees up and no flush is pending.
    always_comb begin
        if ((state_r == ST_IDLE) && !bus.flush) begin
            in_ready_s = !out_valid_r || bus.out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = bus.in_valid && in_ready_s;
    assign hs_s     = out_valid_r && bus.out_ready;

    // Sequencer next-state: dispatch load, chained load, overrun/illegal handling and flush.
    always_comb begin
        state_s       = state_r;
        out_valid_s   = out_valid_r;
        out_ctrl_s    = out_ctrl_r;
        out_last_s    = out_last_r;
        out_illegal_s = out_illegal_r;
        upc_s         = upc_r;
        step_cnt_s    = step_cnt_r;

        if (bus.flush) begin
            state_s       = ST_IDLE;
            out_valid_s   = 1'b0;
            out_last_s    = 1'b0;
            out_illegal_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        out_valid_s = 1'b1;
                        step_cnt_s  = 9'd1;
                        if (disp_valid_s) begin
                            out_ctrl_s    = entry_ctrl(disp_entry_s);
                            out_last_s    = entry_last(disp_entry_s);
                            out_illegal_s = 1'b0;
                            if (!entry_last(disp_entry_s)) begin
                                state_s = ST_RUN;
                                upc_s   = entry_next(disp_entry_s);
                            end else begin
                                state_s = ST_IDLE;
                            end
                        end else begin
                            out_ctrl_s    = '0;
                            out_last_s    = 1'b1;
                            out_illegal_s = 1'b1;
                        end
                    end else if (hs_s) begin
                        out_valid_s = 1'b0;
                    end else begin
                        out_valid_s = out_valid_r;
                    end
                end
                ST_RUN: begin
                    if (hs_s) begin
                        out_valid_s = 1'b1;
                        step_cnt_s  = step_cnt_r + 9'd1;
                        // A runaway chain is cut off with an illegal terminal word.
                        if ((step_cnt_r + 9'd1) > MAX_STEPS_C) begin
                            out_ctrl_s    = '0;
                            out_last_s    = 1'b1;
                            out_illegal_s = 1'b1;
                            state_s       = ST_IDLE;
                        end else if (!run_valid_s) begin
                            out_ctrl_s    = '0;
                            out_last_s    = 1'b1;
                            out_illegal_s = 1'b1;
                            state_s       = ST_IDLE;
                        end else begin
                            out_ctrl_s    = entry_ctrl(run_entry_s);
                            out_last_s    = entry_last(run_entry_s);
                            out_illegal_s = 1'b0;
                            upc_s         = entry_next(run_entry_s);
                            if (entry_last(run_entry_s)) begin
                                state_s = ST_IDLE;
                            end else begin
                                state_s = ST_RUN;
                            end
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            out_valid_r   <= 1'b0;
            out_ctrl_r    <= '0;
            out_last_r    <= 1'b0;
            out_illegal_r <= 1'b0;
            upc_r         <= '0;
            step_cnt_r    <= '0;
        end else begin
            state_r       <= state_s;
            out_valid_r   <= out_valid_s;
            out_ctrl_r    <= out_ctrl_s;
            out_last_r    <= out_last_s;
            out_illegal_r <= out_illegal_s;
            upc_r         <= upc_s;
            step_cnt_r    <= step_cnt_s;
        end
    end

    // Entry valid bits: cleared by reset, set by any table write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (bus.prog_we) begin
            valid_r[bus.prog_addr] <= 1'b1;
        end
    end

    // Table contents; reset blocks writes but does not scrub data (the valid bit gates it).
    always_ff @(posedge clk) begin
        if (rst_n && bus.prog_we) begin
            mem_r[bus.prog_addr] <= {bus.prog_last, bus.prog_next, bus.prog_ctrl};
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_ctrl    = out_ctrl_r;
    assign bus.out_last    = out_last_r;
    assign bus.out_illegal = out_illegal_r;
    assign bus.busy        = (state_r == ST_RUN);
endmodule
